// File: rtl/instruction_decoder_if.sv
// Decoder bus: fetch/flag/memory-status inputs and decode/control outputs.
interface instruction_decoder_if #(
    parameter int unsigned BITS_FOR_INSTRUCTIONS = 5
) ();
    logic [BITS_FOR_INSTRUCTIONS-1:0] instruction_address;
    logic [15:0]                      instruction;
    logic                             alu_zero;
    logic                             alu_carry;
    logic                             mem_ready;
    logic                             jump_enable;
    logic [BITS_FOR_INSTRUCTIONS-1:0] jump_value;
    logic [2:0]                       alu_op;
    logic [1:0]                       reg_raddr_a;
    logic [1:0]                       reg_raddr_b;
    logic [1:0]                       reg_waddr;
    logic                             reg_we;
    logic [7:0]                       imm;
    logic                             mem_req;
    logic                             mem_we;
    logic                             halted;
    logic                             mem_error;

    // Fetch/datapath side driving the decoder.
    modport master (
        output instruction_address, instruction, alu_zero, alu_carry, mem_ready,
        input  jump_enable, jump_value, alu_op, reg_raddr_a, reg_raddr_b,
               reg_waddr, reg_we, imm, mem_req, mem_we, halted, mem_error
    );

    // Decoder side.
    modport slave (
        input  instruction_address, instruction, alu_zero, alu_carry, mem_ready,
        output jump_enable, jump_value, alu_op, reg_raddr_a, reg_raddr_b,
               reg_waddr, reg_we, imm, mem_req, mem_we, halted, mem_error
    );
endinterface

// File: rtl/instruction_decoder.sv
// Instruction decoder: combinational decode from state/instruction/flags,
// with a small FSM for memory waits (with timeout) and halt.
module instruction_decoder #(
    parameter int unsigned BITS_FOR_INSTRUCTIONS = 5,
    parameter int unsigned MEM_TIMEOUT           = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    instruction_decoder_if.slave  bus
);
    localparam int unsigned AW = BITS_FOR_INSTRUCTIONS;
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(MEM_TIMEOUT - 1);

    localparam logic [3:0] OP_ALU  = 4'h1;
    localparam logic [3:0] OP_LDI  = 4'h2;
    localparam logic [3:0] OP_JMP  = 4'h3;
    localparam logic [3:0] OP_JZ   = 4'h4;
    localparam logic [3:0] OP_JC   = 4'h5;
    localparam logic [3:0] OP_LD   = 4'h6;
    localparam logic [3:0] OP_ST   = 4'h7;
    localparam logic [3:0] OP_HALT = 4'h8;

    typedef enum logic [1:0] {ST_RUN, ST_MEM_WAIT, ST_HALT} state_t;

    state_t          r_state;
    logic            r_flag_z;
    logic            r_flag_c;
    logic [CW-1:0]   r_cnt;
    logic            r_halted;
    logic            r_mem_error;

    state_t          w_state_nxt;
    logic            w_flag_z_nxt;
    logic            w_flag_c_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_halted_nxt;
    logic            w_mem_error_nxt;

    logic            w_jump_enable;
    logic [AW-1:0]   w_jump_value;
    logic [2:0]      w_alu_op;
    logic [1:0]      w_raddr_a;
    logic [1:0]      w_raddr_b;
    logic [1:0]      w_waddr;
    logic            w_reg_we;
    logic [7:0]      w_imm;
    logic            w_mem_req;
    logic            w_mem_we;

    logic [3:0]      w_opcode;
    logic [1:0]      w_rd;
    logic [1:0]      w_ra;
    logic [1:0]      w_rb;
    logic [2:0]      w_func;
    logic [7:0]      w_imm_f;
    logic [AW-1:0]   w_target;

    assign w_opcode = bus.instruction[15:12];
    assign w_rd     = bus.instruction[11:10];
    assign w_ra     = bus.instruction[9:8];
    assign w_rb     = bus.instruction[7:6];
    assign w_func   = bus.instruction[5:3];
    assign w_imm_f  = bus.instruction[7:0];
    assign w_target = bus.instruction[AW-1:0];

    // State and status registers; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_RUN;
            r_flag_z    <= 1'b0;
            r_flag_c    <= 1'b0;
            r_cnt       <= '0;
            r_halted    <= 1'b0;
            r_mem_error <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_flag_z    <= w_flag_z_nxt;
            r_flag_c    <= w_flag_c_nxt;
            r_cnt       <= w_cnt_nxt;
            r_halted    <= w_halted_nxt;
            r_mem_error <= w_mem_error_nxt;
        end
    end

    // Next-state and decode outputs; everything forced to 0 while in reset.
    always_comb begin
        w_state_nxt     = r_state;
        w_flag_z_nxt    = r_flag_z;
        w_flag_c_nxt    = r_flag_c;
        w_cnt_nxt       = r_cnt;
        w_halted_nxt    = r_halted;
        w_mem_error_nxt = r_mem_error;
        w_jump_enable   = 1'b0;
        w_jump_value    = '0;
        w_alu_op        = '0;
        w_raddr_a       = '0;
        w_raddr_b       = '0;
        w_waddr         = '0;
        w_reg_we        = 1'b0;
        w_imm           = '0;
        w_mem_req       = 1'b0;
        w_mem_we        = 1'b0;

        if (rst) begin
            case (r_state)
                ST_RUN: begin
                    case (w_opcode)
                        OP_ALU: begin
                            w_alu_op     = w_func;
                            w_raddr_a    = w_ra;
                            w_raddr_b    = w_rb;
                            w_waddr      = w_rd;
                            w_reg_we     = 1'b1;
                            w_flag_z_nxt = bus.alu_zero;
                            w_flag_c_nxt = bus.alu_carry;
                        end
                        OP_LDI: begin
                            w_waddr  = w_rd;
                            w_imm    = w_imm_f;
                            w_reg_we = 1'b1;
                        end
                        OP_JMP: begin
                            w_jump_enable = 1'b1;
                            w_jump_value  = w_target;
                        end
                        OP_JZ: begin
                            w_jump_enable = r_flag_z;
                            w_jump_value  = r_flag_z ? w_target : '0;
                        end
                        OP_JC: begin
                            w_jump_enable = r_flag_c;
                            w_jump_value  = r_flag_c ? w_target : '0;
                        end
                        OP_LD, OP_ST: begin
                            w_mem_req     = 1'b1;
                            w_mem_we      = (w_opcode == OP_ST);
                            w_imm         = w_imm_f;
                            w_raddr_a     = w_ra;
                            w_jump_enable = 1'b1;
                            w_jump_value  = bus.instruction_address;
                            w_state_nxt   = ST_MEM_WAIT;
                            w_cnt_nxt     = '0;
                        end
                        OP_HALT: begin
                            w_jump_enable = 1'b1;
                            w_jump_value  = bus.instruction_address;
                            w_state_nxt   = ST_HALT;
                            w_halted_nxt  = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_MEM_WAIT: begin
                    w_mem_req = 1'b1;
                    w_mem_we  = (w_opcode == OP_ST);
                    w_imm     = w_imm_f;
                    w_raddr_a = w_ra;
                    w_cnt_nxt = r_cnt + CW'(1);
                    if (bus.mem_ready) begin
                        w_state_nxt = ST_RUN;
                        if (w_opcode == OP_LD) begin
                            w_reg_we = 1'b1;
                            w_waddr  = w_rd;
                        end
                    end else if (r_cnt < TIMEOUT_LAST) begin
                        w_jump_enable = 1'b1;
                        w_jump_value  = bus.instruction_address;
                    end else begin
                        w_mem_error_nxt = 1'b1;
                        w_state_nxt     = ST_RUN;
                    end
                end
                ST_HALT: begin
                    w_jump_enable = 1'b1;
                    w_jump_value  = bus.instruction_address;
                end
                default: w_state_nxt = ST_RUN;
            endcase
        end
    end

    assign bus.jump_enable = w_jump_enable;
    assign bus.jump_value  = w_jump_value;
    assign bus.alu_op      = w_alu_op;
    assign bus.reg_raddr_a = w_raddr_a;
    assign bus.reg_raddr_b = w_raddr_b;
    assign bus.reg_waddr   = w_waddr;
    assign bus.reg_we      = w_reg_we;
    assign bus.imm         = w_imm;
    assign bus.mem_req     = w_mem_req;
    assign bus.mem_we      = w_mem_we;
    assign bus.halted      = rst & r_halted;
    assign bus.mem_error   = rst & r_mem_error;
endmodule

// File: tb/tb_instruction_decoder.sv
// Directed bench for instruction_decoder (BITS_FOR_INSTRUCTIONS=5, MEM_TIMEOUT=15).
module tb_instruction_decoder;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    instruction_decoder_if #(.BITS_FOR_INSTRUCTIONS(5)) bus ();

    instruction_decoder #(
        .BITS_FOR_INSTRUCTIONS(5),
        .MEM_TIMEOUT(15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the fetch/flag/memory inputs.
    task automatic drive(input logic [4:0] addr, input logic [15:0] ins,
                         input logic az, input logic ac, input logic mr);
        bus.instruction_address = addr;
        bus.instruction         = ins;
        bus.alu_zero            = az;
        bus.alu_carry           = ac;
        bus.mem_ready           = mr;
    endtask

    // Compare the full output bundle {je,jv,alu_op,ra,rb,wa,we,imm,req,mwe,halted,err}.
    task automatic expect_out(input string tag,
                              input logic je, input logic [4:0] jv, input logic [2:0] aop,
                              input logic [1:0] ra, input logic [1:0] rb, input logic [1:0] wa,
                              input logic we, input logic [7:0] imm, input logic req,
                              input logic mwe, input logic h, input logic e);
        logic [27:0] obs;
        logic [27:0] exp;
        obs = {bus.jump_enable, bus.jump_value, bus.alu_op, bus.reg_raddr_a, bus.reg_raddr_b,
               bus.reg_waddr, bus.reg_we, bus.imm, bus.mem_req, bus.mem_we, bus.halted,
               bus.mem_error};
        exp = {je, jv, aop, ra, rb, wa, we, imm, req, mwe, h, e};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%07h expected=%07h", tag, obs, exp);
        end
    endtask

    task automatic expect_zero(input string tag, input logic h, input logic e);
        expect_out(tag, 1'b0, 5'h00, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, h, e);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        drive(5'h00, 16'h2CA5, 1'b1, 1'b1, 1'b1);

        // Reset: outputs zero regardless of instruction.
        @(negedge clk); #1;
        expect_zero("reset_ldi", 1'b0, 1'b0);
        @(negedge clk); drive(5'h00, 16'h6940, 1'b0, 1'b0, 1'b0); #1;
        expect_zero("reset_ld", 1'b0, 1'b0);

        @(negedge clk); rst = 1'b1; drive(5'h00, 16'h0000, 1'b0, 1'b0, 1'b0); #1;
        expect_zero("nop_after_reset", 1'b0, 1'b0);

        // LDI rd=3 imm=A5
        @(negedge clk); drive(5'h01, 16'h2CA5, 1'b0, 1'b0, 1'b0); #1;
        expect_out("ldi", 1'b0, 5'h00, 3'd0, 2'd0, 2'd0, 2'd3, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);

        // ALU rd=1 ra=2 rb=3 func=5, zero=1 carry=0
        @(negedge clk); drive(5'h02, 16'h16E8, 1'b1, 1'b0, 1'b0); #1;
        expect_out("alu_z1", 1'b0, 5'h00, 3'd5, 2'd2, 2'd3, 2'd1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // JZ 0x1A uses registered flag_z=1 even with alu_zero input low
        @(negedge clk); drive(5'h03, 16'h401A, 1'b0, 1'b1, 1'b0); #1;
        expect_out("jz_taken", 1'b1, 5'h1A, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        @(negedge clk); drive(5'h04, 16'h501A, 1'b0, 1'b1, 1'b0); #1;
        expect_zero("jc_not_taken", 1'b0, 1'b0);

        // ALU func=0, zero=0 carry=1
        @(negedge clk); drive(5'h05, 16'h1000, 1'b0, 1'b1, 1'b0); #1;
        expect_out("alu_c1", 1'b0, 5'h00, 3'd0, 2'd0, 2'd0, 2'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        @(negedge clk); drive(5'h06, 16'h401A, 1'b1, 1'b0, 1'b0); #1;
        expect_zero("jz_not_taken", 1'b0, 1'b0);

        @(negedge clk); drive(5'h07, 16'h5015, 1'b0, 1'b0, 1'b0); #1;
        expect_out("jc_taken", 1'b1, 5'h15, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // JMP: only target bits [4:0] used
        @(negedge clk); drive(5'h09, 16'h3FE7, 1'b0, 1'b0, 1'b0); #1;
        expect_out("jmp", 1'b1, 5'h07, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Opcode 0xC and NOP: nothing, flags unchanged
        @(negedge clk); drive(5'h0A, 16'hCFFF, 1'b1, 1'b0, 1'b1); #1;
        expect_zero("op_c", 1'b0, 1'b0);
        @(negedge clk); drive(5'h0B, 16'h0FFF, 1'b1, 1'b0, 1'b1); #1;
        expect_zero("nop_ff", 1'b0, 1'b0);
        @(negedge clk); drive(5'h0C, 16'h5003, 1'b0, 1'b0, 1'b0); #1;
        expect_out("jc_flags_kept", 1'b1, 5'h03, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); drive(5'h0D, 16'h4003, 1'b1, 1'b0, 1'b0); #1;
        expect_zero("jz_flags_kept", 1'b0, 1'b0);

        // LD rd=2 ra=1 imm=0x40 at 0x0A; mem_ready in RUN is ignored, ready on 3rd wait cycle
        @(negedge clk); drive(5'h0A, 16'h6940, 1'b0, 1'b0, 1'b1); #1;
        expect_out("ld_run", 1'b1, 5'h0A, 3'd0, 2'd1, 2'd0, 2'd0, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk); drive(5'h0A, 16'h6940, 1'b0, 1'b0, 1'b0); #1;
        expect_out("ld_wait0", 1'b1, 5'h0A, 3'd0, 2'd1, 2'd0, 2'd0, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #1;
        expect_out("ld_wait1", 1'b1, 5'h0A, 3'd0, 2'd1, 2'd0, 2'd0, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk); bus.mem_ready = 1'b1; #1;
        expect_out("ld_done", 1'b0, 5'h00, 3'd0, 2'd1, 2'd0, 2'd2, 1'b1, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk); drive(5'h0B, 16'h0000, 1'b0, 1'b0, 1'b1); #1;
        expect_zero("ld_back_to_run", 1'b0, 1'b0);

        // ST ra=3 imm=0x55 at 0x0B, never ready: 16 cycles then abort with mem_error
        @(negedge clk); drive(5'h0B, 16'h7355, 1'b0, 1'b0, 1'b0); #1;
        expect_out("st_run", 1'b1, 5'h0B, 3'd0, 2'd3, 2'd0, 2'd0, 1'b0, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk); #1;
            expect_out($sformatf("st_wait%0d", i), 1'b1, 5'h0B, 3'd0, 2'd3, 2'd0, 2'd0, 1'b0,
                       8'h55, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        @(negedge clk); #1;
        expect_out("st_timeout", 1'b0, 5'h00, 3'd0, 2'd3, 2'd0, 2'd0, 1'b0, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk); drive(5'h0C, 16'h0000, 1'b0, 1'b0, 1'b0); #1;
        expect_zero("st_err_run", 1'b0, 1'b1);
        @(negedge clk); drive(5'h0D, 16'h2411, 1'b0, 1'b0, 1'b0); #1;
        expect_out("ldi_err_sticky", 1'b0, 5'h00, 3'd0, 2'd0, 2'd0, 2'd1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset during LD wait aborts immediately
        @(negedge clk); drive(5'h10, 16'h6422, 1'b0, 1'b0, 1'b0); #1;
        expect_out("ld2_run", 1'b1, 5'h10, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk); #1;
        expect_out("ld2_wait0", 1'b1, 5'h10, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk); rst = 1'b0; bus.mem_ready = 1'b1; #1;
        expect_zero("ld2_reset_abort", 1'b0, 1'b0);
        @(negedge clk); rst = 1'b1; drive(5'h11, 16'h0000, 1'b0, 1'b0, 1'b1); #1;
        expect_zero("ld2_after_reset", 1'b0, 1'b0);
        @(negedge clk); drive(5'h12, 16'h4005, 1'b0, 1'b0, 1'b0); #1;
        expect_zero("jz_flag_cleared", 1'b0, 1'b0);
        @(negedge clk); drive(5'h13, 16'h5005, 1'b0, 1'b0, 1'b0); #1;
        expect_zero("jc_flag_cleared", 1'b0, 1'b0);

        // HALT at 0x07: PC held, halted sticky, other instructions ignored
        @(negedge clk); drive(5'h07, 16'h8000, 1'b0, 1'b0, 1'b0); #1;
        expect_out("halt_run", 1'b1, 5'h07, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); drive(5'h07, 16'h16E8, 1'b1, 1'b1, 1'b1); #1;
        expect_out("halt_alu", 1'b1, 5'h07, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk); drive(5'h07, 16'h7355, 1'b0, 1'b0, 1'b1); #1;
        expect_out("halt_st", 1'b1, 5'h07, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk); drive(5'h07, 16'h3FE1, 1'b0, 1'b0, 1'b0); #1;
        expect_out("halt_jmp", 1'b1, 5'h07, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk); rst = 1'b0; #1;
        expect_zero("halt_reset", 1'b0, 1'b0);
        @(negedge clk); rst = 1'b1; drive(5'h00, 16'h2CA5, 1'b0, 1'b0, 1'b0); #1;
        expect_out("ldi_after_halt", 1'b0, 5'h00, 3'd0, 2'd0, 2'd0, 2'd3, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
